// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_pkg
//  Purpose  : Shared segment encodings, FSM states, register map and the
//             double-dabble step used by the 7-segment display controller.
//  Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] c_SEG_0     = 7'b1000000;
    localparam logic [6:0] c_SEG_1     = 7'b1111001;
    localparam logic [6:0] c_SEG_2     = 7'b0100100;
    localparam logic [6:0] c_SEG_3     = 7'b0110000;
    localparam logic [6:0] c_SEG_4     = 7'b0011001;
    localparam logic [6:0] c_SEG_5     = 7'b0010010;
    localparam logic [6:0] c_SEG_6     = 7'b0000010;
    localparam logic [6:0] c_SEG_7     = 7'b1111000;
    localparam logic [6:0] c_SEG_8     = 7'b0000000;
    localparam logic [6:0] c_SEG_9     = 7'b0010000;
    localparam logic [6:0] c_SEG_A     = 7'b0001000;
    localparam logic [6:0] c_SEG_B     = 7'b0000011;
    localparam logic [6:0] c_SEG_C     = 7'b1000110;
    localparam logic [6:0] c_SEG_D     = 7'b0100001;
    localparam logic [6:0] c_SEG_E     = 7'b0000110;
    localparam logic [6:0] c_SEG_F     = 7'b0001110;
    localparam logic [6:0] c_SEG_DASH  = 7'b0111111;
    localparam logic [6:0] c_SEG_UNLIT = 7'b1111111;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CONV = 2'd1;
    localparam logic [1:0] c_ST_LOAD = 2'd2;

    localparam logic c_ADDR_DATA = 1'b0;
    localparam logic c_ADDR_CTRL = 1'b1;

    localparam int c_CTRL_MODE  = 0;
    localparam int c_CTRL_BLANK = 1;

    // One double-dabble iteration on {bcd[19:0], bin[15:0]}: add-3 then shift
    function automatic logic [35:0] dabble_step(input logic [35:0] v);
        logic [35:0] t;
        t = v;
        for (int d = 0; d < 5; d++) begin
            if (t[16 + 4*d +: 4] >= 4'd5)
                t[16 + 4*d +: 4] = t[16 + 4*d +: 4] + 4'd3;
        end
        return {t[34:0], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`default_nettype none
// ============================================================================
//  Module   : hex_to_7seg
//  Purpose  : Combinational nibble to active-low 7-segment pattern decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module hex_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = c_SEG_0;
        case (i_nibble)
            4'h0: o_seg = c_SEG_0;
            4'h1: o_seg = c_SEG_1;
            4'h2: o_seg = c_SEG_2;
            4'h3: o_seg = c_SEG_3;
            4'h4: o_seg = c_SEG_4;
            4'h5: o_seg = c_SEG_5;
            4'h6: o_seg = c_SEG_6;
            4'h7: o_seg = c_SEG_7;
            4'h8: o_seg = c_SEG_8;
            4'h9: o_seg = c_SEG_9;
            4'hA: o_seg = c_SEG_A;
            4'hB: o_seg = c_SEG_B;
            4'hC: o_seg = c_SEG_C;
            4'hD: o_seg = c_SEG_D;
            4'hE: o_seg = c_SEG_E;
            default: o_seg = c_SEG_F;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_display_ctrl
//  Purpose  : Four-digit 7-segment controller with hex or decimal (BCD) view.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        busy,
    output logic [6:0]  one,
    output logic [6:0]  two,
    output logic [6:0]  three,
    output logic [6:0]  four
);

    logic [15:0] r_data;
    logic        r_mode;
    logic        r_blank;
    logic [1:0]  r_state;
    logic [3:0]  r_iter;
    logic [15:0] r_bin;
    logic [19:0] r_bcd;
    logic [6:0]  r_digit [4];
    logic [6:0]  r_seg   [4];

    logic        w_data_wr;
    logic        w_ctrl_wr;
    logic        w_start;
    logic        w_show_hex;
    logic        w_commit;
    logic        w_overflow;
    logic        w_blank_next;
    logic [15:0] w_src;
    logic [15:0] w_dec_in;
    logic [6:0]  w_dec_out   [4];
    logic [6:0]  w_digit_next [4];

    function automatic logic [6:0] polarize(input logic [6:0] p);
        return SEG_ACTIVE_LOW ? p : ~p;
    endfunction

    assign w_data_wr  = wr_en && (addr == c_ADDR_DATA);
    assign w_ctrl_wr  = wr_en && (addr == c_ADDR_CTRL);
    assign w_src      = w_data_wr ? wdata : r_data;
    // Entering decimal mode or writing DATA in it (re)starts a conversion
    assign w_start    = (w_data_wr && r_mode) ||
                        (w_ctrl_wr && !r_mode && wdata[c_CTRL_MODE]);
    assign w_show_hex = (w_data_wr && !r_mode) ||
                        (w_ctrl_wr && r_mode && !wdata[c_CTRL_MODE]);
    assign w_commit   = (r_state == c_ST_LOAD) && !w_start && !w_show_hex;
    assign w_overflow = (r_bcd[19:16] != 4'd0);
    assign w_dec_in   = w_commit ? r_bcd[15:0] : w_src;
    assign w_blank_next = w_ctrl_wr ? wdata[c_CTRL_BLANK] : r_blank;

    assign busy  = (r_state != c_ST_IDLE);
    assign rdata = (addr == c_ADDR_CTRL) ? {13'd0, busy, r_blank, r_mode} : r_data;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_digit
            hex_to_7seg u_dec (
                .i_nibble (w_dec_in[4*k +: 4]),
                .o_seg    (w_dec_out[k])
            );

            always_comb begin
                w_digit_next[k] = r_digit[k];
                if (w_show_hex)
                    w_digit_next[k] = w_dec_out[k];
                else if (w_commit)
                    w_digit_next[k] = w_overflow ? c_SEG_DASH : w_dec_out[k];
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_digit[k] <= c_SEG_0;
                    r_seg[k]   <= polarize(c_SEG_0);
                end else begin
                    r_digit[k] <= w_digit_next[k];
                    r_seg[k]   <= polarize(w_blank_next ? c_SEG_UNLIT : w_digit_next[k]);
                end
            end
        end
    endgenerate

    assign one   = r_seg[0];
    assign two   = r_seg[1];
    assign three = r_seg[2];
    assign four  = r_seg[3];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data  <= 16'd0;
            r_mode  <= 1'b0;
            r_blank <= 1'b0;
            r_state <= c_ST_IDLE;
            r_iter  <= 4'd0;
            r_bin   <= 16'd0;
            r_bcd   <= 20'd0;
        end else begin
            if (w_data_wr)
                r_data <= wdata;
            if (w_ctrl_wr) begin
                r_mode  <= wdata[c_CTRL_MODE];
                r_blank <= wdata[c_CTRL_BLANK];
            end

            if (w_start) begin
                r_state <= c_ST_CONV;
                r_iter  <= 4'd0;
                r_bin   <= w_src;
                r_bcd   <= 20'd0;
            end else if (w_show_hex) begin
                r_state <= c_ST_IDLE;
                r_iter  <= 4'd0;
            end else begin
                case (r_state)
                    c_ST_CONV: begin
                        {r_bcd, r_bin} <= dabble_step({r_bcd, r_bin});
                        r_iter <= r_iter + 4'd1;
                        if (r_iter == 4'd15)
                            r_state <= c_ST_LOAD;
                    end
                    c_ST_LOAD: r_state <= c_ST_IDLE;
                    default:   r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_display_ctrl
//  Purpose  : Directed self-checking bench for seg_display_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_ctrl;

    localparam logic [6:0] c_S0 = 7'b1000000, c_S1 = 7'b1111001, c_S2 = 7'b0100100,
                           c_S3 = 7'b0110000, c_S4 = 7'b0011001, c_S5 = 7'b0010010,
                           c_S6 = 7'b0000010, c_S9 = 7'b0010000, c_SA = 7'b0001000,
                           c_SF = 7'b0001110, c_DASH = 7'b0111111, c_OFF = 7'b1111111;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic        addr  = 1'b0;
    logic [15:0] wdata = 16'd0;
    logic [15:0] rdata;
    logic        busy;
    logic [6:0]  one, two, three, four;

    int vectors    = 0;
    int miscompares = 0;

    seg_display_ctrl #(.SEG_ACTIVE_LOW(1'b1)) dut (
        .clock (clock), .reset (reset), .wr_en (wr_en), .addr (addr),
        .wdata (wdata), .rdata (rdata), .busy  (busy),
        .one   (one),   .two   (two),   .three (three), .four (four)
    );

    always #5 clock = ~clock;

    task automatic write_reg(input logic a, input logic [15:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        @(posedge clock); #1;
        wr_en = 1'b0; addr = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 40) begin
            @(posedge clock); #1;
            cycles++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; wr_en = 1'b1; addr = 1'b0; wdata = 16'hFFFF;
        @(posedge clock); #1;
        reset = 1'b0; wr_en = 1'b0; addr = 1'b1; #1;
        vectors++;
        if ({four, three, two, one} !== {c_S0, c_S0, c_S0, c_S0}) begin
            miscompares++;
            $display("FAIL reset_digits got %b %b %b %b want all %b", four, three, two, one, c_S0);
        end
        vectors++;
        if (busy !== 1'b0 || rdata !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl busy=%b rdata=%h want busy=0 rdata=0000", busy, rdata);
        end
        addr = 1'b0; #1;
        vectors++;
        if (rdata !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_data rdata=%h want 0000", rdata);
        end
    endtask

    task automatic test_hex;
        write_reg(1'b0, 16'h1A3F);
        vectors++;
        if ({four, three, two, one} !== {c_S1, c_SA, c_S3, c_SF} || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL hex_1A3F got %b %b %b %b busy=%b want %b %b %b %b busy=0",
                     four, three, two, one, busy, c_S1, c_SA, c_S3, c_SF);
        end
        vectors++;
        if (rdata !== 16'h1A3F) begin
            miscompares++;
            $display("FAIL hex_readback rdata=%h want 1a3f", rdata);
        end
    endtask

    task automatic test_decimal;
        int cnt;
        int changed;
        write_reg(1'b1, 16'h0001);
        write_reg(1'b0, 16'h04D2);
        cnt = 0; changed = 0;
        while (busy && cnt < 40) begin
            if ({four, three, two, one} !== {c_S1, c_SA, c_S3, c_SF}) changed++;
            @(posedge clock); #1;
            cnt++;
        end
        vectors++;
        if (cnt !== 17) begin
            miscompares++;
            $display("FAIL dec_busy_len got %0d cycles want 17", cnt);
        end
        vectors++;
        if (changed !== 0) begin
            miscompares++;
            $display("FAIL dec_hold got %0d changed cycles want 0", changed);
        end
        vectors++;
        if ({four, three, two, one} !== {c_S1, c_S2, c_S3, c_S4}) begin
            miscompares++;
            $display("FAIL dec_1234 got %b %b %b %b want %b %b %b %b",
                     four, three, two, one, c_S1, c_S2, c_S3, c_S4);
        end
        addr = 1'b1; #1;
        vectors++;
        if (rdata !== 16'h0001) begin
            miscompares++;
            $display("FAIL dec_ctrl_rd rdata=%h want 0001", rdata);
        end
        addr = 1'b0;
    endtask

    task automatic test_overflow;
        int cnt;
        write_reg(1'b0, 16'h2710);
        wait_idle(cnt);
        vectors++;
        if (cnt !== 17 || {four, three, two, one} !== {c_DASH, c_DASH, c_DASH, c_DASH}) begin
            miscompares++;
            $display("FAIL dec_10000 cycles=%0d got %b %b %b %b want 17 and all %b",
                     cnt, four, three, two, one, c_DASH);
        end
    endtask

    task automatic test_back_to_back;
        int cnt;
        int saw5;
        saw5 = 0;
        write_reg(1'b0, 16'h0005);
        repeat (4) begin
            @(posedge clock); #1;
            if (one === c_S5) saw5++;
        end
        write_reg(1'b0, 16'h0009);
        cnt = 0;
        while (busy && cnt < 40) begin
            if (one === c_S5) saw5++;
            @(posedge clock); #1;
            cnt++;
        end
        vectors++;
        if (cnt !== 17) begin
            miscompares++;
            $display("FAIL b2b_busy_len got %0d want 17", cnt);
        end
        vectors++;
        if (saw5 !== 0 || {four, three, two, one} !== {c_S0, c_S0, c_S0, c_S9}) begin
            miscompares++;
            $display("FAIL b2b_0009 saw5=%0d got %b %b %b %b want 0 and %b %b %b %b",
                     saw5, four, three, two, one, c_S0, c_S0, c_S0, c_S9);
        end
    endtask

    task automatic test_blank;
        int cnt;
        write_reg(1'b1, 16'h0003);
        vectors++;
        if ({four, three, two, one} !== {c_OFF, c_OFF, c_OFF, c_OFF} || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL blank_on got %b %b %b %b busy=%b want all %b busy=0",
                     four, three, two, one, busy, c_OFF);
        end
        write_reg(1'b0, 16'h0042);
        wait_idle(cnt);
        vectors++;
        if (cnt !== 17 || {four, three, two, one} !== {c_OFF, c_OFF, c_OFF, c_OFF}) begin
            miscompares++;
            $display("FAIL blank_conv cycles=%0d got %b %b %b %b want 17 and all %b",
                     cnt, four, three, two, one, c_OFF);
        end
        write_reg(1'b1, 16'h0001);
        vectors++;
        if ({four, three, two, one} !== {c_S0, c_S0, c_S6, c_S6}) begin
            miscompares++;
            $display("FAIL blank_off got %b %b %b %b want %b %b %b %b",
                     four, three, two, one, c_S0, c_S0, c_S6, c_S6);
        end
    endtask

    task automatic test_abort;
        write_reg(1'b0, 16'h1234);
        repeat (3) @(posedge clock);
        #1;
        write_reg(1'b1, 16'h0000);
        vectors++;
        if (busy !== 1'b0 || {four, three, two, one} !== {c_S1, c_S2, c_S3, c_S4}) begin
            miscompares++;
            $display("FAIL abort_hex busy=%b got %b %b %b %b want 0 and %b %b %b %b",
                     busy, four, three, two, one, c_S1, c_S2, c_S3, c_S4);
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        write_reg(1'b1, 16'h0001);
        repeat (5) @(posedge clock);
        #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_busy busy=%b want 1", busy);
        end
        test_reset;
        bad = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (busy !== 1'b0 || {four, three, two, one} !== {c_S0, c_S0, c_S0, c_S0}) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL mid_no_partial got %0d bad cycles want 0", bad);
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        test_reset;
        test_hex;
        test_decimal;
        test_overflow;
        test_back_to_back;
        test_blank;
        test_abort;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 Parameter SEG_ACTIVE_LOW, default 1: 1 = segment lit when bit is 0; 0 inverts all segment outputs.
REQ-002 Port clock, input, 1: single system clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port wr_en, input, 1: CPU register write strobe, sampled each rising edge.
REQ-005 Port addr, input, 1: register select; 0 = DATA, 1 = CTRL.
REQ-006 Port wdata, input, 16: write data.
REQ-007 Port rdata, output, 16: combinational readback of the register selected by addr.
REQ-008 Port busy, output, 1: high while a decimal conversion is in progress.
REQ-009 Ports one, two, three, four, output, 7 each: registered segment patterns; one = least-significant digit, four = most-significant digit; bit order {g,f,e,d,c,b,a}.

Function
REQ-010 DATA: 16-bit value; CTRL bit0 = mode (0 hex, 1 decimal), bit1 = blank; other CTRL bits ignored on write, read as 0.
REQ-011 rdata: addr 0 -> DATA; addr 1 -> {13'b0, busy, blank, mode}.
REQ-012 Hex mode: DATA write at edge N loads DATA and the four segment registers with nibbles [3:0]->one ... [15:12]->four at the same edge; busy stays 0.
REQ-013 Decimal mode: FSM states IDLE, CONV, LOAD; a DATA write in IDLE moves to CONV at edge N; busy = 1 in CONV and LOAD.
REQ-014 CONV runs exactly 16 shift/add-3 (double-dabble) iterations, one per edge (N+1..N+16), using a 4-bit iteration counter; it then enters LOAD.
REQ-015 LOAD commits at edge N+17: value <= 9999 -> four BCD digits, leading zeros shown; value > 9999 -> all four digits show dash (g only); then IDLE, busy = 0.
REQ-016 Segment outputs hold their previous patterns throughout CONV and LOAD until the commit edge.
REQ-017 DATA write during CONV or LOAD loads the new value and restarts CONV at iteration 0; busy stays high; the result reflects only the latest value (latest wins).
REQ-018 CTRL write that sets mode 0->1 starts a conversion of the current DATA, as for a DATA write; setting mode 1->0 aborts any conversion (IDLE, busy 0) and shows DATA in hex at the same edge.
REQ-019 blank = 1 forces all outputs to the unlit pattern; conversion and register updates continue underneath; clearing blank shows the current digit patterns in the next cycle.
REQ-020 Active-low encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110, dash=0111111, unlit=1111111.
REQ-021 Writes to CTRL while busy do not restart a conversion unless REQ-018 applies.

Reset
REQ-022 Reset takes priority over every simultaneous write.
REQ-023 On reset: DATA = 0, CTRL = 0 (hex, not blanked), FSM = IDLE, iteration counter = 0, busy = 0, and one..four = 1000000 ("0"), all from the next edge.
REQ-024 Reset during CONV or LOAD discards the conversion; no partial result is ever displayed.

Structure
REQ-025 Shared package seg_pkg holds the segment encoding constants (including dash and unlit), FSM state encoding, register address constants, and CTRL bit indices.
REQ-026 One sub-module, hex_to_7seg: combinational 4-bit to 7-segment decoder, instantiated four times; polarity is applied once at the output register stage.

Verification
REQ-027 Reset pulse -> one..four = 1000000, busy = 0, rdata(addr 1) = 0.
REQ-028 Hex mode, write DATA 0x1A3F -> next cycle one=0001110, two=0110000, three=0001000, four=1111001.
REQ-029 CTRL=1, then DATA 0x04D2 (1234) -> busy high exactly 17 cycles, outputs unchanged meanwhile, then four=1111001, three=0100100, two=0110000, one=0011001.
REQ-030 Decimal mode, write DATA 0x2710 (10000) -> after 17 cycles all four = 0111111.
REQ-031 Decimal mode, write 0x0005, then 0x0009 five cycles later -> busy stays high 17 cycles past the second write; final display 0009; the digit 5 is never shown.
REQ-032 CTRL blank=1 -> all 1111111, then clear -> prior digits return; reset asserted mid-conversion -> busy 0 and "0000" next cycle.
